serial_adder: RTL and testbench

//  Bit-serial N-bit unsigned adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.

---
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit unsigned adder: one full-adder cell and a carry flop, LSB first.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
`ifdef SERIAL_ADDER_CIN_EN
   input  logic         cin,
`endif
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y,
   output logic         cout,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   sa, sb;
   logic [CW-1:0]  cnt;
   logic           carry;
   logic           s, carry_nxt, last, cin_init;
   logic [N-1:0]   y_shift;

`ifdef SERIAL_ADDER_CIN_EN
   assign cin_init = cin;
`else
   assign cin_init = 1'b0;
`endif

   // Single full-adder cell; the new sum bit enters y from the top so y fills LSB last.
   always_comb begin
      s              = sa[0] ^ sb[0] ^ carry;
      carry_nxt      = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
      last           = (cnt == CW'(N - 1));
      y_shift        = y >> 1;
      y_shift[N-1]   = s;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         y     <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  carry <= cin_init;
                  cnt   <= '0;
                  y     <= '0;
                  cout  <= 1'b0;
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               carry <= carry_nxt;
               y     <= y_shift;
               cnt   <= cnt + 1'b1;
               if (last) cout <= carry_nxt;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (N=4); carry-in cases run when
// SERIAL_ADDER_CIN_EN is defined.
module tb_serial_adder;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         cin;
   logic [N-1:0] a, b;
   logic [N-1:0] y;
   logic         cout, busy, done;

   int checks = 0;
   int errors = 0;

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADDER_CIN_EN
      .cin   (cin),
`endif
      .a     (a),
      .b     (b),
      .y     (y),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands with start for one rising edge; returns at the negedge after acceptance.
   task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tcin);
      @(negedge clk);
      a     = ta;
      b     = tb;
      cin   = tcin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts rising edges from the accepting edge (=1) until done is seen high.
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("done_timeout", done, 1'b1);
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tcin, input logic [N-1:0] ey, input logic ec);
      int lat;
      start_op(ta, tb, tcin);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      wait_done(lat);
      check({tag, "_lat"}, lat, N + 1);
      check({tag, "_y"}, y, ey);
      check({tag, "_cout"}, cout, ec);
      @(negedge clk);
      check({tag, "_done_drop"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      check({tag, "_y_hold"}, y, ey);
   endtask

   initial begin
      int pulses, t, last_t;
      logic [N-1:0] y_at_done;
      logic         c_at_done;

      rst   = 1'b1;
      start = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst_y", y, 0);
      check("rst_cout", cout, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;

      run_op("add_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
      run_op("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
      run_op("add_0_0", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);

      // Start re-pulsed with new operands during RUN must be ignored.
      start_op(4'd3, 4'd4, 1'b0);
      a     = 4'd9;
      b     = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      pulses    = 0;
      y_at_done = '0;
      c_at_done = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) begin
            pulses++;
            y_at_done = y;
            c_at_done = cout;
         end
         @(negedge clk);
      end
      check("ignore_pulses", pulses, 1);
      check("ignore_y", y_at_done, 4'd7);
      check("ignore_cout", c_at_done, 1'b0);

      // Reset during the second RUN cycle aborts at once with no done afterwards.
      start_op(4'd1, 4'd0, 1'b0);
      @(negedge clk);
      check("abort_partial_y", y, 4'd8);
      rst = 1'b1;
      #1;
      check("abort_y", y, 0);
      check("abort_cout", cout, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check("abort_no_done", pulses, 0);

      // Back-to-back with start held high: done every N+2 cycles.
      @(negedge clk);
      a      = 4'd7;
      b      = 4'd7;
      start  = 1'b1;
      t      = 0;
      last_t = -1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         t++;
         if (done === 1'b1) begin
            pulses++;
            check("b2b_y", y, 4'd14);
            check("b2b_cout", cout, 1'b0);
            if (last_t < 0) check("b2b_first_lat", t, N + 1);
            else            check("b2b_period", t - last_t, N + 2);
            last_t = t;
         end
      end
      start = 1'b0;
      check("b2b_pulses", pulses, 3);
      repeat (N + 3) @(negedge clk);

`ifdef SERIAL_ADDER_CIN_EN
      run_op("cin_7_8_1", 4'd7, 4'd8, 1'b1, 4'd0, 1'b1);
      run_op("cin_7_8_0", 4'd7, 4'd8, 1'b0, 4'd15, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
